// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, transmitter FSM states and
// the baud divisor rounding used by the transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with fall-through read data and a registered full flag,
// so a write is judged against the occupancy at the start of the cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ALMOST = (AW+1)'(DEPTH - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign do_wr   = wr && !full;
  assign do_rd   = rd && !empty;
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous push and pop leaves occupancy untouched.
      case ({do_wr, do_rd})
        2'b10: begin
          level <= level + (AW+1)'(1);
          full  <= (level == LVL_ALMOST);
        end
        2'b01: begin
          level <= level - (AW+1)'(1);
          full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO feeds a start/data/parity/stop framer,
// frames are sent back-to-back while the FIFO holds data.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  input  logic                          I_tx_valid,
  input  logic [DATA_BITS-1:0]          I_tx_data,
  output logic                          O_tx_ready,
  output logic                          O_rs232_txd,
  output logic                          O_tx_busy,
  output logic                          O_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   O_fifo_level
);

  localparam int DIV = (BAUD > 0) ? baud_div(CLK_FREQ, BAUD) : 0;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_err_data
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_err_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_fifo
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BAUD <= 0 || DIV < 2) begin : g_err_div
    $error("uart_tx_param: CLK_FREQ/BAUD must give at least 2 clocks per bit");
  end

  tx_state_e            state_q, state_n;
  logic [DW-1:0]        div_q, div_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic                 stop_q, stop_n;
  logic [DATA_BITS-1:0] sh_q, sh_n;
  logic                 par_q, par_n;
  logic                 txd_q, txd_n;

  logic                 fifo_rd, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 div_end, load, done;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .wr      (I_tx_valid),
    .wr_data (I_tx_data),
    .rd      (fifo_rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (O_fifo_level)
  );

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    stop_n  = stop_q;
    sh_n    = sh_q;
    par_n   = par_q;
    txd_n   = txd_q;
    fifo_rd = 1'b0;
    load    = 1'b0;
    done    = 1'b0;

    if (state_q != ST_IDLE) div_n = div_end ? '0 : div_q + DW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (div_end) begin
          state_n = ST_DATA;
          bit_n   = '0;
          txd_n   = sh_q[0];
        end
      end
      ST_DATA: begin
        if (div_end) begin
          if (bit_q == BIT_LAST) begin
            if (PARITY != PARITY_NONE) begin
              state_n = ST_PARITY;
              txd_n   = par_q;
            end else begin
              state_n = ST_STOP;
              stop_n  = 1'b0;
              txd_n   = 1'b1;
            end
          end else begin
            bit_n = bit_q + BW'(1);
            sh_n  = {1'b0, sh_q[DATA_BITS-1:1]};
            txd_n = sh_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (div_end) begin
          state_n = ST_STOP;
          stop_n  = 1'b0;
          txd_n   = 1'b1;
        end
      end
      ST_STOP: begin
        if (div_end) begin
          if (stop_q == STOP_LAST) begin
            done = 1'b1;
            // Chain straight into the next frame when data is waiting.
            if (!fifo_empty) load = 1'b1;
            else             state_n = ST_IDLE;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (load) begin
      fifo_rd = 1'b1;
      state_n = ST_START;
      div_n   = '0;
      sh_n    = fifo_dout;
      par_n   = (^fifo_dout) ^ (PARITY == PARITY_ODD);
      txd_n   = 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      stop_q  <= stop_n;
      sh_q    <= sh_n;
      par_q   <= par_n;
      txd_q   <= txd_n;
    end
  end

  assign O_rs232_txd = txd_q;
  assign O_tx_ready  = !fifo_full;
  assign O_tx_busy   = (state_q != ST_IDLE);
  assign O_tx_done   = done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed + random bench for uart_tx_param: three parameterizations are
// checked against a per-frame bit list built from the line format rules.
module tb_uart_tx_param;

  localparam int N = 3;
  localparam int DIVS  [N] = '{434, 10, 10};
  localparam int DBITS [N] = '{8, 8, 7};
  localparam int PARS  [N] = '{0, 1, 2};
  localparam int STOPS [N] = '{1, 1, 2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] vld = '0;
  logic [7:0]   dat [N];
  wire  [N-1:0] rdy, txd, busy, done;
  wire  [4:0]   lvl0, lvl1;
  wire  [2:0]   lvl2;
  logic [4:0]   lvl [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    lvl[0] = lvl0;
    lvl[1] = lvl1;
    lvl[2] = {2'b00, lvl2};
  end

  uart_tx_param u0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_tx_valid(vld[0]), .I_tx_data(dat[0]),
    .O_tx_ready(rdy[0]), .O_rs232_txd(txd[0]), .O_tx_busy(busy[0]),
    .O_tx_done(done[0]), .O_fifo_level(lvl0)
  );

  uart_tx_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_tx_valid(vld[1]), .I_tx_data(dat[1]),
    .O_tx_ready(rdy[1]), .O_rs232_txd(txd[1]), .O_tx_busy(busy[1]),
    .O_tx_done(done[1]), .O_fifo_level(lvl1)
  );

  uart_tx_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u2 (
    .I_clk(clk), .I_rst_n(rst_n), .I_tx_valid(vld[2]), .I_tx_data(dat[2][6:0]),
    .O_tx_ready(rdy[2]), .O_rs232_txd(txd[2]), .O_tx_busy(busy[2]),
    .O_tx_done(done[2]), .O_fifo_level(lvl2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic [7:0] d);
    vld[k] = 1'b1;
    dat[k] = d;
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  // Expected line waveform: start, LSB-first payload, optional parity, stops.
  task automatic run_frame(input int k, input logic [7:0] d, input string tag,
                           output int wait_cyc);
    logic q[$];
    logic p;
    int   bad, dcnt, dpos, total;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < DBITS[k]; i++) begin
      q.push_back(d[i]);
      p ^= d[i];
    end
    if (PARS[k] == 1)      q.push_back(p);
    else if (PARS[k] == 2) q.push_back(~p);
    for (int i = 0; i < STOPS[k]; i++) q.push_back(1'b1);
    total = q.size() * DIVS[k];
    wait_cyc = 0;
    while (txd[k] !== 1'b0 && wait_cyc < 10000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, " start"}, 32'(txd[k] === 1'b0), 1);
    bad = 0; dcnt = 0; dpos = -1;
    for (int c = 0; c < total; c++) begin
      if (txd[k] !== q[c / DIVS[k]] || busy[k] !== 1'b1) bad++;
      if (done[k] === 1'b1) begin
        dcnt++;
        dpos = c;
      end
      @(negedge clk);
    end
    check({tag, " bits"}, bad, 0);
    check({tag, " done count"}, dcnt, 1);
    check({tag, " done position"}, dpos, total - 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         w;
    logic [7:0] d;
    logic [7:0] burst [$];
    for (int k = 0; k < N; k++) dat[k] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset txd u%0d", k),   txd[k],  1);
      check($sformatf("reset busy u%0d", k),  busy[k], 0);
      check($sformatf("reset done u%0d", k),  done[k], 0);
      check($sformatf("reset ready u%0d", k), rdy[k],  1);
      check($sformatf("reset level u%0d", k), lvl[k],  0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle without write txd", txd, 3'b111);
    check("idle without write busy", busy, 3'b000);

    // Default parameters, 0x55
    drive(0, 8'h55);
    check("def55 txd before pop", txd[0], 1);
    check("def55 level after write", lvl[0], 1);
    run_frame(0, 8'h55, "def55", w);
    check("def55 pop latency", w, 1);
    check("def55 busy after", busy[0], 0);
    check("def55 level after", lvl[0], 0);
    check("def55 txd after", txd[0], 1);

    d = 8'($urandom);
    drive(0, d);
    run_frame(0, d, "def random", w);

    // Reset in the middle of data bit 3 with more data queued
    d = 8'($urandom);
    drive(0, d);
    drive(0, 8'($urandom));
    drive(0, 8'($urandom));
    repeat (4 * DIVS[0] + DIVS[0] / 2 - 1) @(negedge clk);
    check("mid-frame data bit3", txd[0], 32'(d[3]));
    check("mid-frame busy", busy[0], 1);
    check("mid-frame level", lvl[0], 2);
    rst_n = 1'b0;
    #1;
    check("async reset txd", txd[0], 1);
    check("async reset busy", busy[0], 0);
    check("async reset done", done[0], 0);
    check("async reset level", lvl[0], 0);
    check("async reset ready", rdy[0], 1);
    repeat (4) @(negedge clk);
    check("reset hold done", done, 3'b000);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post reset idle busy", busy[0], 0);
    check("post reset idle txd", txd[0], 1);
    check("post reset level", lvl[0], 0);
    d = 8'($urandom);
    drive(0, d);
    run_frame(0, d, "post reset frame", w);
    check("post reset pop latency", w, 1);

    // Even parity, 0x07
    drive(1, 8'h07);
    run_frame(1, 8'h07, "even07", w);
    d = 8'($urandom);
    drive(1, d);
    run_frame(1, d, "even random", w);

    // 18 back-to-back writes, then a write against a full FIFO during a pop
    for (int i = 0; i < 18; i++) burst.push_back(8'($urandom));
    fork
      begin
        int t;
        for (int i = 0; i < 18; i++) begin
          check($sformatf("burst ready %0d", i), rdy[1], 32'(i < 17));
          vld[1] = 1'b1;
          dat[1] = burst[i];
          @(negedge clk);
        end
        vld[1] = 1'b0;
        check("burst full level", lvl[1], 16);
        check("burst full ready", rdy[1], 0);
        t = 0;
        while (done[1] !== 1'b1 && t < 500) begin
          @(negedge clk);
          t++;
        end
        check("full pop cycle reached", done[1], 1);
        check("full pop cycle ready", rdy[1], 0);
        vld[1] = 1'b1;
        dat[1] = 8'hA5;
        @(negedge clk);
        vld[1] = 1'b0;
        check("full write+pop level", lvl[1], 15);
        check("full write+pop ready", rdy[1], 1);
      end
      begin
        int g;
        for (int i = 0; i < 17; i++) begin
          run_frame(1, burst[i], $sformatf("burst frame %0d", i), g);
          if (i > 0) check($sformatf("burst gap %0d", i), g, 0);
        end
      end
    join
    check("burst end busy", busy[1], 0);
    check("burst end level", lvl[1], 0);

    // Odd parity, 7 data bits, 2 stop bits
    drive(2, 8'h00);
    run_frame(2, 8'h00, "odd00", w);
    burst.delete();
    for (int i = 0; i < 3; i++) burst.push_back(8'($urandom) & 8'h7F);
    fork
      begin
        for (int i = 0; i < 3; i++) drive(2, burst[i]);
      end
      begin
        int g;
        for (int i = 0; i < 3; i++) begin
          run_frame(2, burst[i], $sformatf("odd frame %0d", i), g);
          if (i > 0) check($sformatf("odd gap %0d", i), g, 0);
        end
      end
    join
    check("odd end busy", busy[2], 0);
    check("odd end level", lvl[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, payload width.
REQ-004 SHALL have parameter PARITY, default 0, 0=none 1=even 2=odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, power of two >=2, TX buffer entries.
REQ-007 SHALL have port I_clk, input, 1, single system clock, all logic on rising edge.
REQ-008 SHALL have port I_rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port I_tx_valid, input, 1, write request.
REQ-010 SHALL have port I_tx_data, input, DATA_BITS, byte to send.
REQ-011 SHALL have port O_tx_ready, output, 1, FIFO not full.
REQ-012 SHALL have port O_rs232_txd, output, 1, serial line, idle high.
REQ-013 SHALL have port O_tx_busy, output, 1, high when FSM not IDLE.
REQ-014 SHALL have port O_tx_done, output, 1, one-cycle pulse per finished frame.
REQ-015 SHALL have port O_fifo_level, output, $clog2(FIFO_DEPTH)+1, current entry count.

Function
REQ-016 Write SHALL be accepted on a cycle with I_tx_valid && O_tx_ready; otherwise data is ignored, no error state.
REQ-017 O_tx_ready SHALL be registered-level !full; when full, a write in the same cycle as a pop SHALL still be refused.
REQ-018 Bit period SHALL be DIV = (CLK_FREQ + BAUD/2)/BAUD clocks (434 at defaults); the divider SHALL count 0..DIV-1 and run only when not IDLE, restarting at 0 on each frame start.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE with FIFO non-empty SHALL pop one entry into the shift register and enter START on the next edge, driving txd low from that edge (1-cycle pop latency).
REQ-021 START lasts 1 bit period, then DATA.
REQ-022 DATA SHALL send DATA_BITS bits LSB first, 1 period each, then PARITY if PARITY!=0, else STOP.
REQ-023 Parity bit SHALL be XOR of payload bits (even) or its inverse (odd).
REQ-024 STOP SHALL drive high for STOP_BITS periods.
REQ-025 At the last clock of STOP, O_tx_done SHALL pulse high for exactly one cycle.
REQ-026 At the end of STOP, FIFO non-empty SHALL pop and enter START directly (no idle gap); otherwise enter IDLE.
REQ-027 O_rs232_txd SHALL be driven from a register, glitch-free.
REQ-028 O_fifo_level SHALL be +1 on write only, -1 on pop only, unchanged on simultaneous write+pop; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 Reset assertion SHALL immediately, mid-frame included, force: FSM IDLE, O_rs232_txd=1, O_tx_busy=0, O_tx_done=0, O_tx_ready=1, O_fifo_level=0, divider/bit counters 0, FIFO emptied.
REQ-030 After deassertion the first frame SHALL start only after a new write.

Structure
REQ-031 Shared package uart_pkg SHALL hold PARITY mode constants, FSM state enum, and the DIV rounding function.
REQ-032 FIFO SHALL be one sub-module uart_sync_fifo (parameters WIDTH, DEPTH; ports wr/rd/full/empty/level); all else in uart_tx_param.
REQ-033 Illegal parameter values SHALL fail elaboration.

Verification
REQ-034 Defaults, write 0x55 -> txd low 434 clks, then 1,0,1,0,1,0,1,0 at 434 clks each, stop high 434; done pulses once at clk 4340 after START.
REQ-035 PARITY=1, write 0x07 -> parity bit 1; PARITY=2, write 0x00 -> parity bit 1; STOP_BITS=2 -> stop high 868 clks.
REQ-036 18 writes back-to-back -> first 17 accepted (16 stored + 1 popped), ready low at level 16; 17 frames sent with no idle gap between stop and next start.
REQ-037 Write while full with same-cycle pop -> write refused, level 15 next cycle.
REQ-038 Reset at mid DATA bit 3 -> txd high next edge, level 0, busy 0, no done pulse; new write afterwards sends a complete correct frame.
